// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core constants, fetch FSM state type and helpers
package core_pkg;

  localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  // Major opcodes shared with decode and immediate generation
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic {
    REQ  = 1'b0,
    WAIT = 1'b1
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - fetch-stage bus: imem request/response, redirect and decode handshake
interface instr_fetch_if;

  logic        imemReqValid;
  logic        imemReqReady;
  logic [31:0] imemReqAddr;
  logic        imemRespValid;
  logic [31:0] imemRespData;
  logic        redirectValid;
  logic [31:0] redirectPc;
  logic        instrValid;
  logic        instrReady;
  logic [31:0] instruction;
  logic [31:0] instrPc;

  modport master (
    output imemReqValid, imemReqAddr, instrValid, instruction, instrPc,
    input  imemReqReady, imemRespValid, imemRespData, redirectValid, redirectPc, instrReady
  );

  modport slave (
    input  imemReqValid, imemReqAddr, instrValid, instruction, instrPc,
    output imemReqReady, imemRespValid, imemRespData, redirectValid, redirectPc, instrReady
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - power-of-two FIFO of {instruction, pc} with flush; NOP/0 head when empty
module fetch_fifo
  import core_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [31:0]   push_data,
  input  logic [31:0]   push_pc,
  input  logic          pop,
  input  logic          flush,
  output logic [31:0]   head_data,
  output logic [31:0]   head_pc,
  output logic [CW-1:0] count
);

  logic [31:0]   mem_data [DEPTH];
  logic [31:0]   mem_pc   [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && (count < CW'(DEPTH));
  assign do_pop  = pop && (count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count covers them
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem_data[wr_ptr] <= push_data;
      mem_pc[wr_ptr]   <= push_pc;
    end
  end

  assign head_data = (count == '0) ? INSTR_NOP : mem_data[rd_ptr];
  assign head_pc   = (count == '0) ? 32'h0    : mem_pc[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - RV32I fetch stage: PC, single-outstanding imem fetch, output FIFO, redirect
// Optional FETCH_PERF_CNT_EN adds fetchCount/dropCount performance counters.
module instr_fetch
  import core_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  instr_fetch_if.master      bus
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetchCount,
  output logic [31:0]        dropCount
`endif
);

  localparam int CW = $clog2(BUF_DEPTH) + 1;

  fetch_state_e  state, state_nxt;
  logic [31:0]   pc, pc_nxt;
  logic [31:0]   req_pc, req_pc_nxt;
  logic          discard, discard_nxt;
  logic [CW-1:0] fifo_count;
  logic          fifo_push;
  logic          fifo_pop;
  logic          redirect;
  logic          req_fire;

  assign redirect = bus.redirectValid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= REQ;
      pc      <= RESET_PC;
      req_pc  <= RESET_PC;
      discard <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      req_pc  <= req_pc_nxt;
      discard <= discard_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    pc_nxt           = pc;
    req_pc_nxt       = req_pc;
    discard_nxt      = discard;
    bus.imemReqValid = 1'b0;
    req_fire         = 1'b0;
    fifo_push        = 1'b0;
    case (state)
      REQ: begin
        // Only request when a FIFO slot is guaranteed for the response
        bus.imemReqValid = rst_n && (fifo_count < CW'(BUF_DEPTH)) && !redirect;
        req_fire         = bus.imemReqValid && bus.imemReqReady;
        if (req_fire) begin
          req_pc_nxt = pc;
          pc_nxt     = pc + 32'd4;
          state_nxt  = WAIT;
        end
      end
      WAIT: begin
        if (bus.imemRespValid) begin
          fifo_push   = !discard && !redirect;
          discard_nxt = 1'b0;
          state_nxt   = REQ;
        end else if (redirect) begin
          discard_nxt = 1'b1;
        end
      end
    endcase
    if (redirect) pc_nxt = word_align(bus.redirectPc);
  end

  assign bus.imemReqAddr = pc;
  assign bus.instrValid  = (fifo_count != '0);
  assign fifo_pop        = bus.instrValid && bus.instrReady && !redirect;

  fetch_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .push_data (bus.imemRespData),
    .push_pc   (req_pc),
    .pop       (fifo_pop),
    .flush     (redirect),
    .head_data (bus.instruction),
    .head_pc   (bus.instrPc),
    .count     (fifo_count)
  );

`ifdef FETCH_PERF_CNT_EN
  logic resp_drop;
  assign resp_drop = (state == WAIT) && bus.imemRespValid && (discard || redirect);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetchCount <= '0;
      dropCount  <= '0;
    end else begin
      if (fifo_pop) fetchCount <= fetchCount + 32'd1;
      dropCount <= dropCount + 32'(resp_drop) + (redirect ? 32'(fifo_count) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard bench for instr_fetch with a latency-configurable imem model
module tb_instr_fetch;

  logic clk;
  logic rst_n;
  instr_fetch_if bus();
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] drop_count;
`endif

  instr_fetch #(
    .RESET_PC  (32'h0000_0000),
    .BUF_DEPTH (2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetchCount (fetch_count),
    .dropCount  (drop_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          vectors;
  int          miscompares;
  int          cyc;
  int          lat;
  int          pend;
  int          drop_n;
  logic [31:0] pend_addr;
  logic [63:0] sb[$];
  logic [31:0] req_q[$];
  logic [31:0] pop_q[$];
  int          req_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // One clock: monitor pops against the scoreboard, log requests, then play memory
  task automatic step();
    logic        f, p, r;
    logic [31:0] a;
    logic [63:0] exp;
    #1;
    f = bus.imemReqValid && bus.imemReqReady;
    a = bus.imemReqAddr;
    r = bus.redirectValid;
    p = bus.instrValid && bus.instrReady && !r;
    if (p) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL sb_pop: got pc=%h data=%h, required no output", bus.instrPc, bus.instruction);
      end else begin
        exp = sb.pop_front();
        if ({bus.instruction, bus.instrPc} !== exp) begin
          miscompares++;
          $display("FAIL sb_pop: got data=%h pc=%h, required data=%h pc=%h",
                   bus.instruction, bus.instrPc, exp[63:32], exp[31:0]);
        end
      end
      pop_q.push_back(bus.instrPc);
    end
    if (f) begin
      req_q.push_back(a);
      req_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (r) sb.delete();
    bus.redirectValid = 1'b0;
    bus.imemRespValid = 1'b0;
    if (f) begin
      pend      = lat;
      pend_addr = a;
    end
    if (pend == 1) begin
      bus.imemRespValid = 1'b1;
      bus.imemRespData  = mem_word(pend_addr);
      if (drop_n > 0) drop_n--;
      else sb.push_back({mem_word(pend_addr), pend_addr});
      pend = 0;
    end else if (pend > 1) begin
      pend--;
    end
  endtask

  task automatic do_reset();
    rst_n             = 1'b0;
    bus.imemReqReady  = 1'b1;
    bus.imemRespValid = 1'b0;
    bus.imemRespData  = '0;
    bus.redirectValid = 1'b0;
    bus.redirectPc    = '0;
    pend   = 0;
    drop_n = 0;
    repeat (2) @(posedge clk);
    #1;
    sb.delete();
    req_q.delete();
    pop_q.delete();
    req_cyc.delete();
    cyc   = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.imemReqValid !== 1'b0) begin miscompares++; $display("FAIL rst_req_valid: got %b required 0", bus.imemReqValid); end
    vectors++; if (bus.instrValid !== 1'b0) begin miscompares++; $display("FAIL rst_instr_valid: got %b required 0", bus.instrValid); end
    vectors++; if (bus.instruction !== 32'h0000_0013) begin miscompares++; $display("FAIL rst_nop: got %h required 00000013", bus.instruction); end
    vectors++; if (bus.instrPc !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h required 0", bus.instrPc); end
`ifdef FETCH_PERF_CNT_EN
    vectors++; if (fetch_count !== 32'h0 || drop_count !== 32'h0) begin miscompares++; $display("FAIL rst_perf: got %h/%h required 0/0", fetch_count, drop_count); end
`endif
    do_reset();
  endtask

  task automatic test_streaming();
    lat = 1;
    bus.instrReady = 1'b1;
    do_reset();
    for (int i = 0; i < 40 && pop_q.size() < 4; i++) step();
    vectors++; if (pop_q.size() < 4) begin miscompares++; $display("FAIL stream_timeout: got %0d pops required 4", pop_q.size()); end
    for (int i = 0; i < 4; i++) begin
      vectors++; if (pop_q[i] !== 32'(i * 4)) begin miscompares++; $display("FAIL stream_pc%0d: got %h required %h", i, pop_q[i], i * 4); end
      vectors++; if (req_q[i] !== 32'(i * 4)) begin miscompares++; $display("FAIL stream_req%0d: got %h required %h", i, req_q[i], i * 4); end
    end
    vectors++; if (req_cyc[1] - req_cyc[0] !== 2) begin miscompares++; $display("FAIL stream_rate01: got %0d required 2", req_cyc[1] - req_cyc[0]); end
    vectors++; if (req_cyc[3] - req_cyc[2] !== 2) begin miscompares++; $display("FAIL stream_rate23: got %0d required 2", req_cyc[3] - req_cyc[2]); end
`ifdef FETCH_PERF_CNT_EN
    vectors++; if (fetch_count !== 32'(pop_q.size())) begin miscompares++; $display("FAIL stream_fetch_cnt: got %0d required %0d", fetch_count, pop_q.size()); end
`endif
  endtask

  task automatic test_stall();
    lat = 1;
    bus.instrReady = 1'b0;
    do_reset();
    repeat (10) step();
    #1;
    vectors++; if (req_q.size() !== 2) begin miscompares++; $display("FAIL stall_reqs: got %0d required 2", req_q.size()); end
    vectors++; if (bus.imemReqValid !== 1'b0) begin miscompares++; $display("FAIL stall_req_valid: got %b required 0", bus.imemReqValid); end
    vectors++; if (bus.instrValid !== 1'b1) begin miscompares++; $display("FAIL stall_valid: got %b required 1", bus.instrValid); end
    vectors++; if (bus.instrPc !== 32'h0) begin miscompares++; $display("FAIL stall_head: got %h required 0", bus.instrPc); end
    bus.instrReady = 1'b1;
    for (int i = 0; i < 30 && (pop_q.size() < 2 || req_q.size() < 3); i++) step();
    vectors++; if (pop_q[0] !== 32'h0) begin miscompares++; $display("FAIL stall_drain0: got %h required 0", pop_q[0]); end
    vectors++; if (pop_q[1] !== 32'h4) begin miscompares++; $display("FAIL stall_drain1: got %h required 4", pop_q[1]); end
    vectors++; if (req_q[2] !== 32'h8) begin miscompares++; $display("FAIL stall_resume: got %h required 8", req_q[2]); end
  endtask

  task automatic test_redirect_wait();
    int n, p0;
    lat = 2;
    bus.instrReady = 1'b1;
    do_reset();
    for (int i = 0; i < 40 && req_q.size() < 3; i++) step();
    vectors++; if (req_q[2] !== 32'h8) begin miscompares++; $display("FAIL rw_pre: got %h required 8", req_q[2]); end
    bus.redirectValid = 1'b1;
    bus.redirectPc    = 32'h0000_0100;
    drop_n            = 1;
    #1;
    vectors++; if (bus.imemReqValid !== 1'b0) begin miscompares++; $display("FAIL rw_req_valid: got %b required 0", bus.imemReqValid); end
    step();
    vectors++; if (bus.instrValid !== 1'b0) begin miscompares++; $display("FAIL rw_flush: got %b required 0", bus.instrValid); end
    n  = req_q.size();
    p0 = pop_q.size();
    for (int i = 0; i < 40 && (req_q.size() <= n || pop_q.size() <= p0); i++) step();
    vectors++; if (req_q[n] !== 32'h100) begin miscompares++; $display("FAIL rw_req_addr: got %h required 00000100", req_q[n]); end
    vectors++; if (pop_q[p0] !== 32'h100) begin miscompares++; $display("FAIL rw_first_pc: got %h required 00000100", pop_q[p0]); end
  endtask

  task automatic test_redirect_resp();
    int n, p0;
    lat = 1;
    bus.instrReady = 1'b1;
    do_reset();
    for (int i = 0; i < 40 && req_q.size() < 2; i++) step();
    vectors++; if (bus.imemRespValid !== 1'b1) begin miscompares++; $display("FAIL rr_resp_now: got %b required 1", bus.imemRespValid); end
    bus.redirectValid = 1'b1;
    bus.redirectPc    = 32'h0000_0203;
    step();
    n  = req_q.size();
    p0 = pop_q.size();
    for (int i = 0; i < 40 && (req_q.size() <= n || pop_q.size() <= p0); i++) step();
    vectors++; if (req_q[n] !== 32'h200) begin miscompares++; $display("FAIL rr_req_addr: got %h required 00000200", req_q[n]); end
    vectors++; if (pop_q[p0] !== 32'h200) begin miscompares++; $display("FAIL rr_first_pc: got %h required 00000200", pop_q[p0]); end
  endtask

  task automatic test_wrap();
    lat = 1;
    bus.instrReady = 1'b1;
    do_reset();
    bus.redirectValid = 1'b1;
    bus.redirectPc    = 32'hFFFF_FFFC;
    #1;
    vectors++; if (bus.imemReqValid !== 1'b0) begin miscompares++; $display("FAIL wrap_req_valid: got %b required 0", bus.imemReqValid); end
    step();
    for (int i = 0; i < 40 && (req_q.size() < 2 || pop_q.size() < 1); i++) step();
    vectors++; if (req_q[0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_req0: got %h required fffffffc", req_q[0]); end
    vectors++; if (req_q[1] !== 32'h0) begin miscompares++; $display("FAIL wrap_req1: got %h required 00000000", req_q[1]); end
    vectors++; if (pop_q[0] !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL wrap_pop: got %h required fffffffc", pop_q[0]); end
  endtask

  task automatic test_reset_mid_wait();
    lat = 2;
    bus.instrReady = 1'b0;
    do_reset();
    for (int i = 0; i < 40 && req_q.size() < 2; i++) step();
    vectors++; if (bus.instrValid !== 1'b1) begin miscompares++; $display("FAIL rmw_pre_valid: got %b required 1", bus.instrValid); end
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.instrValid !== 1'b0) begin miscompares++; $display("FAIL rmw_valid: got %b required 0", bus.instrValid); end
    vectors++; if (bus.imemReqValid !== 1'b0) begin miscompares++; $display("FAIL rmw_req_valid: got %b required 0", bus.imemReqValid); end
`ifdef FETCH_PERF_CNT_EN
    vectors++; if (fetch_count !== 32'h0 || drop_count !== 32'h0) begin miscompares++; $display("FAIL rmw_perf: got %h/%h required 0/0", fetch_count, drop_count); end
`endif
    bus.instrReady = 1'b1;
    do_reset();
    for (int i = 0; i < 20 && req_q.size() < 1; i++) step();
    vectors++; if (req_q[0] !== 32'h0) begin miscompares++; $display("FAIL rmw_first_req: got %h required 00000000", req_q[0]); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    lat         = 1;
    pend        = 0;
    drop_n      = 0;
    pend_addr   = '0;
    bus.instrReady = 1'b1;
    test_reset();
    test_streaming();
    test_stall();
    test_redirect_wait();
    test_redirect_resp();
    test_wrap();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule
